// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, default timing constants and small helpers
// for the PLL bring-up / reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAITLK = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pll_state_t;

  localparam int DEF_PLL_RST_CYC  = 16;
  localparam int DEF_LOCK_TIMEOUT = 65535;
  localparam int DEF_STABLE_CYC   = 1024;
  localparam int CNT_W            = 16;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into
// the reference clock domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for lock, demands a
// stable lock window, then releases the downstream reset; retries on loss.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYC   = DEF_STABLE_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] fault_cnt,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);

  pll_state_t       cur_state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fault_inc;
  logic             lock_s;
  logic             pll_reset_d, run_d;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock),
    .q     (lock_s)
  );

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state and never see a combinational input path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= PLLRST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault_cnt <= 4'd0;
    end else begin
      cur_state <= next_state;
      cnt       <= cnt_next;
      pll_reset <= pll_reset_d;
      sys_rst_n <= run_d;
      ready     <= run_d;
      if (fault_inc) begin
        fault_cnt <= sat_inc4(fault_cnt);
      end
    end
  end

  // The shared counter only advances below each terminal value, so it
  // cannot wrap; restart overrides every other transition and never faults.
  always_comb begin
    next_state = cur_state;
    cnt_next   = cnt;
    fault_inc  = 1'b0;
    if (restart) begin
      next_state = PLLRST;
      cnt_next   = '0;
    end else begin
      case (cur_state)
        PLLRST: begin
          if (cnt == PLL_RST_LAST) begin
            next_state = WAITLK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        WAITLK: begin
          if (lock_s) begin
            next_state = STABLE;
            cnt_next   = '0;
          end else if (cnt == LOCK_LAST) begin
            next_state = PLLRST;
            cnt_next   = '0;
            fault_inc  = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            next_state = WAITLK;
            cnt_next   = '0;
          end else if (cnt == STABLE_LAST) begin
            next_state = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            next_state = PLLRST;
            cnt_next   = '0;
            fault_inc  = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    pll_reset_d = (next_state == PLLRST);
    run_d       = (next_state == RUN);
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: stimulus queues cycle-tagged expected
// outputs, a negedge monitor pops and compares them as their cycle arrives.
module tb_pll_reset_ctrl;
  import pll_ctrl_pkg::*;

  typedef struct {
    int         cyc;
    string      name;
    pll_state_t st;
    logic       pr;
    logic       srn;
    logic       rdy;
    logic [3:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, lock, restart;
  logic       pll_reset, sys_rst_n, ready;
  logic [3:0] fault_cnt;
  logic [1:0] state;

  int   cyc = 0;
  int   base = 0;
  int   check_cnt = 0;
  int   pass_cnt = 0;
  exp_t sb[$];

  pll_reset_ctrl #(
    .PLL_RST_CYC  (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYC   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lock      (lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault_cnt (fault_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_stimulus(input logic r, input logic l, input logic rs);
    rst_n   = r;
    lock    = l;
    restart = rs;
  endtask

  task automatic push(input int rel, input string name, input pll_state_t st,
                      input logic pr, input logic srn, input logic rdy,
                      input logic [3:0] fc);
    exp_t e;
    e.cyc = base + rel; e.name = name; e.st = st;
    e.pr = pr; e.srn = srn; e.rdy = rdy; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic wait_rel(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input exp_t e);
    check_cnt++;
    if (e.cyc == cyc && state == e.st && pll_reset === e.pr &&
        sys_rst_n === e.srn && ready === e.rdy && fault_cnt === e.fc) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s @cyc %0d (due %0d): got state=%0d pll_reset=%b sys_rst_n=%b ready=%b fault_cnt=%0d, expected state=%0d pll_reset=%b sys_rst_n=%b ready=%b fault_cnt=%0d",
               e.name, cyc, e.cyc, state, pll_reset, sys_rst_n, ready, fault_cnt,
               e.st, e.pr, e.srn, e.rdy, e.fc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      check_output(sb.pop_front());
    end
  end

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0);
    base = 0;
    push(2, "reset_hold_a", PLLRST, 1, 0, 0, 0);
    push(3, "reset_hold_b", PLLRST, 1, 0, 0, 0);
    wait_rel(3);

    // Nominal bring-up: lock first sampled 10 edges after release.
    base = cyc;
    push(3,  "pllrst_last",   PLLRST, 1, 0, 0, 0);
    push(4,  "to_waitlk",     WAITLK, 0, 0, 0, 0);
    push(11, "lock_in_sync",  WAITLK, 0, 0, 0, 0);
    push(12, "to_stable",     STABLE, 0, 0, 0, 0);
    push(19, "stable_last",   STABLE, 0, 0, 0, 0);
    push(20, "nominal_run",   RUN,    0, 1, 1, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_rel(9);
    lock = 1'b1;
    wait_rel(22);

    // Lock loss in RUN, then full re-bring-up.
    base = cyc;
    push(2,  "run_pre_loss",  RUN,    0, 1, 1, 1'b0);
    push(3,  "loss_fault",    PLLRST, 1, 0, 0, 1);
    push(7,  "rebring_wait",  WAITLK, 0, 0, 0, 1);
    push(8,  "rebring_stab",  STABLE, 0, 0, 0, 1);
    push(15, "rebring_last",  STABLE, 0, 0, 0, 1);
    push(16, "rebring_run",   RUN,    0, 1, 1, 1);
    lock = 1'b0;
    wait_rel(3);
    lock = 1'b1;
    wait_rel(18);

    // Restart coincident with lock loss: no fault.
    base = cyc;
    push(2, "run_pre_restart", RUN,    0, 1, 1, 1);
    push(3, "restart_nofault", PLLRST, 1, 0, 0, 1);
    lock = 1'b0;
    wait_rel(2);
    restart = 1'b1;
    wait_rel(3);
    restart = 1'b0;

    // Glitch during STABLE restarts the stability count without a fault.
    base = cyc;
    push(4,  "restart_waitlk", WAITLK, 0, 0, 0, 1);
    push(11, "glitch_stable",  STABLE, 0, 0, 0, 1);
    push(12, "glitch_waitlk",  WAITLK, 0, 0, 0, 1);
    push(13, "glitch_restab",  STABLE, 0, 0, 0, 1);
    push(20, "glitch_last",    STABLE, 0, 0, 0, 1);
    push(21, "glitch_run",     RUN,    0, 1, 1, 1);
    wait_rel(4);
    lock = 1'b1;
    wait_rel(9);
    lock = 1'b0;
    wait_rel(10);
    lock = 1'b1;
    wait_rel(23);

    // Loss in RUN then repeated timeouts; fault count saturates at 15.
    base = cyc;
    push(3,  "loss2_fault",   PLLRST, 1, 0, 0, 2);
    push(7,  "to_wait_to",    WAITLK, 0, 0, 0, 2);
    push(26, "timeout_edge",  WAITLK, 0, 0, 0, 2);
    for (int k = 1; k <= 20; k++) begin
      push(3 + 24 * k, "timeout_retry", PLLRST, 1, 0, 0,
           4'((2 + k > 15) ? 15 : 2 + k));
    end
    lock = 1'b0;
    wait_rel(3 + 24 * 20);

    // Synchronous reset pulsed while waiting for lock.
    base = cyc;
    push(4,  "pre_rst_wait",  WAITLK, 0, 0, 0, 15);
    push(7,  "rst_in_waitlk", PLLRST, 1, 0, 0, 0);
    push(10, "rst_full_hold", PLLRST, 1, 0, 0, 0);
    push(11, "rst_to_waitlk", WAITLK, 0, 0, 0, 0);
    wait_rel(6);
    rst_n = 1'b0;
    wait_rel(7);
    rst_n = 1'b1;
    wait_rel(12);

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("[TB] FAIL watchdog: got cycle %0d, expected completion before 5000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
